// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises Rx, samples each bit at its mid-point with a
// baud counter and hands the byte to the bus through a ready/read handshake.
module uart_rx #(
  parameter int DW           = 8,
  parameter int CLOCK        = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int BAUD_COUNTER = CLOCK / BAUD_RATE,
  parameter int BRW          = $clog2(BAUD_COUNTER + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs,
  input  logic          Rx,
  input  logic          rd_i,
  output logic [DW-1:0] data_o,
  output logic          ready_o,
  output logic          frame_err_o,
  output logic          overrun_o,
  output logic          busy_o
);

  localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BRW-1:0] HALF_M1  = BRW'(BAUD_COUNTER / 2 - 1);
  localparam logic [BRW-1:0] FULL_M1  = BRW'(BAUD_COUNTER - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic           sync1_q, rx_s_q, rx_p_q;
  state_t         state_q, state_d;
  logic [BRW-1:0] cnt_q, cnt_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic [DW-1:0]  data_q, data_d;
  logic           ready_q, ready_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, busy_d;
  logic           sample, done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + BRW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    done    = 1'b0;
    sample  = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cs && rx_p_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (sample) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[DW-1:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + BCW'(1);
        end
      end
      STOP: begin
        if (sample) begin
          cnt_d   = '0;
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Deselect aborts any frame; the bus-side registers are frozen meanwhile.
    if (!cs) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      done    = 1'b0;
    end else begin
      if (rd_i && ready_q) begin
        ready_d = 1'b0;
        ovr_d   = 1'b0;
      end
      // A read landing with the completion frees the slot for the new byte.
      if (done) begin
        if (ready_q && !rd_i) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = shreg_q;
          ready_d = 1'b1;
          ferr_d  = !rx_s_q;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= Rx;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign ready_o     = ready_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 10-clock bit time and an ideal 8N1 driver.
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cs;
  logic       Rx;
  logic       rd_i;
  logic [7:0] data_o;
  logic       ready_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  uart_rx #(.DW(8), .BAUD_COUNTER(10)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cs          (cs),
    .Rx          (Rx),
    .rd_i        (rd_i),
    .data_o      (data_o),
    .ready_o     (ready_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // driver tasks: all inputs change on the falling edge
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    Rx = 1'b0;
    repeat (10) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (10) @(negedge clk_i);
    end
    Rx = stop_bit;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic pulse_rd();
    rd_i = 1'b1;
    @(negedge clk_i);
    rd_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cs = 1'b1; Rx = 1'b1; rd_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_single();
    int n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      while (!ready_o && n < 200) begin
        @(negedge clk_i);
        n++;
      end
    join
    checks++; if (n !== 98) begin errors++; $display("FAIL single_latency got %0d exp 98", n); end
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", data_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", ready_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL single_ferr got %b exp 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL single_ovr got %b exp 0", overrun_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy_o); end
    repeat (5) @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL single_hold got %b exp 1", ready_o); end
    pulse_rd();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL single_rd got %b exp 0", ready_o); end
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_glitch();
    int high = 0;
    int first = -1;
    Rx = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (i == 3) Rx = 1'b1;
      if (busy_o === 1'b1) begin
        high++;
        if (first < 0) first = i;
      end
    end
    checks++; if (high !== 5) begin errors++; $display("FAIL glitch_busy_len got %0d exp 5", high); end
    checks++; if (first !== 3) begin errors++; $display("FAIL glitch_busy_start got %0d exp 3", first); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL glitch_ready got %b exp 0", ready_o); end
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL glitch_data got %h exp a5", data_o); end
  endtask

  task automatic test_frame_err();
    int busy_cnt = 0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0) busy_cnt++;
    end
    Rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0) busy_cnt++;
    end
    checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h exp 3c", data_o); end
    checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", frame_err_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ferr_ready got %b exp 1", ready_o); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL ferr_retrigger got %0d busy cycles exp 0", busy_cnt); end
    pulse_rd();
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk_i);
    checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", data_o); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ovr_ready got %b exp 1", ready_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL ovr_ferr got %b exp 0", frame_err_o); end
    pulse_rd();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ovr_rd_ready got %b exp 0", ready_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_rd_flag got %b exp 0", overrun_o); end
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_simul_read();
    send_frame(8'h33, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (97) @(negedge clk_i);
        rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
      end
    join
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL simul_ready got %b exp 1", ready_o); end
    checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL simul_data got %h exp 55", data_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL simul_ovr got %b exp 0", overrun_o); end
    pulse_rd();
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_abort_reset();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (55) @(negedge clk_i);
        cs = 1'b0;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy_o); end
      end
    join
    repeat (20) @(negedge clk_i);
    cs = 1'b1;
    repeat (20) @(negedge clk_i);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", ready_o); end
    send_frame(8'h0F, 1'b1);
    repeat (5) @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL abort_new_ready got %b exp 1", ready_o); end
    checks++; if (data_o !== 8'h0F) begin errors++; $display("FAIL abort_new_data got %h exp 0f", data_o); end

    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (40) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", data_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b exp 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", overrun_o); end
      end
    join
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    send_frame(8'h5A, 1'b1);
    repeat (5) @(negedge clk_i);
    checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL rst_recover_data got %h exp 5a", data_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_recover_ready got %b exp 1", ready_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simul_read();
    test_abort_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
